// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer: fetch over a valid/ready port, then one-cycle
// decode/regread/execute/writeback enables, with PC, branch and retire count.
module cpu_ctrl_seq #(
  parameter logic [15:0] RESET_VECTOR  = 16'h0000,
  parameter logic [15:0] PC_INC        = 16'd2,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        halt_req,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] inst_in,
  output logic [15:0] inst_out,
  output logic        en_decode,
  output logic        en_regread,
  output logic        en_alu,
  output logic        en_writeback,
  input  logic        should_branch,
  input  logic [15:0] branch_target,
  output logic [15:0] pc,
  output logic [15:0] retired,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_REGREAD   = 3'd3,
    S_EXECUTE   = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALTED    = 3'd6,
    S_ILLEGAL   = 3'd7
  } state_e;

  // Last wait count at which a still-low ready trips the timeout.
  localparam logic [15:0] WAIT_LAST = 16'(FETCH_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] retired_q, retired_d;
  logic [15:0] wait_q, wait_d;
  logic        fault_q, fault_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_VECTOR;
      inst_q    <= 16'h0000;
      retired_q <= 16'h0000;
      wait_q    <= 16'h0000;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    retired_d    = retired_q;
    wait_d       = wait_q;
    fault_d      = fault_q;
    mem_req      = 1'b0;
    en_decode    = 1'b0;
    en_regread   = 1'b0;
    en_alu       = 1'b0;
    en_writeback = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (halt_req)  state_d = S_HALTED;
        else if (en)   state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          inst_d  = inst_in;
          wait_d  = 16'h0000;
          state_d = S_DECODE;
        end else if (FETCH_TIMEOUT != 0 && wait_q == WAIT_LAST) begin
          fault_d = 1'b1;
          state_d = S_HALTED;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_DECODE: begin
        en_decode = 1'b1;
        state_d   = S_REGREAD;
      end
      S_REGREAD: begin
        en_regread = 1'b1;
        state_d    = S_EXECUTE;
      end
      S_EXECUTE: begin
        en_alu  = 1'b1;
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        en_writeback = 1'b1;
        retired_d    = retired_q + 16'd1;
        pc_d         = should_branch ? branch_target : pc_q + PC_INC;
        if (halt_req)  state_d = S_HALTED;
        else if (!en)  state_d = S_IDLE;
        else           state_d = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  assign mem_addr = pc_q;
  assign inst_out = inst_q;
  assign pc       = pc_q;
  assign retired  = retired_q;
  assign state    = state_q;
  assign halted   = (state_q == S_HALTED);
  assign fault    = fault_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Randomized instruction-level bench for cpu_ctrl_seq against a per-instruction
// reference model of fetch waits, stage enables, PC update, retire count and timeout.
module tb_cpu_ctrl_seq;

  localparam logic [15:0] RV = 16'hFFFE;
  localparam int          TO = 8;

  logic        clk = 1'b0;
  logic        reset, en, halt_req, mem_ready, should_branch;
  logic [15:0] inst_in, branch_target;
  logic        mem_req, en_decode, en_regread, en_alu, en_writeback, halted, fault;
  logic [15:0] mem_addr, inst_out, pc, retired;
  logic [2:0]  state;
  logic [4:0]  enables;

  int nvec = 0;
  int nerr = 0;
  int n_instr = 0;
  logic [15:0] exp_pc, exp_ret;

  cpu_ctrl_seq #(.RESET_VECTOR(RV), .PC_INC(16'd2), .FETCH_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .en(en), .halt_req(halt_req),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .inst_in(inst_in),
    .inst_out(inst_out), .en_decode(en_decode), .en_regread(en_regread), .en_alu(en_alu),
    .en_writeback(en_writeback), .should_branch(should_branch), .branch_target(branch_target),
    .pc(pc), .retired(retired), .state(state), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;
  assign enables = {mem_req, en_decode, en_regread, en_alu, en_writeback};

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; halt_req = 1'b0; mem_ready = 1'b0;
    should_branch = 1'b0; branch_target = 16'h0000; inst_in = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
    exp_pc  = RV;
    exp_ret = 16'h0000;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", 32'(pc), 32'(RV));
    check("rst_inst", 32'(inst_out), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_enables", 32'(enables), 32'd0);
  endtask

  // Entered in the first FETCH cycle; w = ready-low cycles before ready.
  task automatic run_instr(input int w, input logic [15:0] word, input logic br,
                           input logic [15:0] tgt, input logic hold_en,
                           input logic do_halt, output logic ended_halted);
    logic timed_out;
    timed_out    = 1'b0;
    ended_halted = 1'b0;
    for (int i = 0; i <= w; i++) begin
      check("fetch_state", 32'(state), 32'd1);
      check("fetch_en", 32'(enables), 32'b10000);
      check("fetch_addr", 32'(mem_addr), 32'(exp_pc));
      mem_ready = (i == w);
      inst_in   = (i == w) ? word : 16'($urandom);
      tick();
      if (i != w && i == TO - 1) begin
        timed_out = 1'b1;
        break;
      end
    end
    mem_ready = 1'b0;
    if (timed_out) begin
      check("to_halted", 32'(halted), 32'd1);
      check("to_fault", 32'(fault), 32'd1);
      check("to_enables", 32'(enables), 32'd0);
      check("to_pc", 32'(pc), 32'(exp_pc));
      en = 1'b1;
      tick();
      tick();
      check("to_sticky_state", 32'(state), 32'd6);
      check("to_sticky_fault", 32'(fault), 32'd1);
      $display("instr %0d addr %h wait %0d -> fetch timeout, halted", n_instr, exp_pc, w);
      n_instr++;
      ended_halted = 1'b1;
      return;
    end
    check("dec_state", 32'(state), 32'd2);
    check("dec_en", 32'(enables), 32'b01000);
    check("dec_inst", 32'(inst_out), 32'(word));
    if (!hold_en) en = 1'b0;
    tick();
    check("rr_en", 32'(enables), 32'b00100);
    check("rr_inst", 32'(inst_out), 32'(word));
    tick();
    check("ex_en", 32'(enables), 32'b00010);
    check("ex_inst", 32'(inst_out), 32'(word));
    if (do_halt) halt_req = 1'b1;
    tick();
    check("wb_en", 32'(enables), 32'b00001);
    check("wb_inst", 32'(inst_out), 32'(word));
    check("wb_retired_before", 32'(retired), 32'(exp_ret));
    should_branch = br;
    branch_target = tgt;
    tick();
    halt_req      = 1'b0;
    should_branch = 1'b0;
    branch_target = 16'($urandom);
    exp_ret = exp_ret + 16'd1;
    exp_pc  = br ? tgt : exp_pc + 16'd2;
    check("retired", 32'(retired), 32'(exp_ret));
    check("pc", 32'(pc), 32'(exp_pc));
    if (do_halt) begin
      check("halt_state", 32'(state), 32'd6);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_enables", 32'(enables), 32'd0);
      en = 1'b1;
      tick();
      tick();
      check("halt_stays", 32'(state), 32'd6);
      check("halt_pc", 32'(pc), 32'(exp_pc));
      ended_halted = 1'b1;
    end else if (!hold_en) begin
      check("idle_state", 32'(state), 32'd0);
      check("idle_enables", 32'(enables), 32'd0);
      en = 1'b1;
      tick();
    end else begin
      check("next_fetch", 32'(state), 32'd1);
    end
    $display("instr %0d inst %h wait %0d br %0d -> pc %h retired %0d%s", n_instr, word, w, br,
             exp_pc, exp_ret, do_halt ? " halted" : (!hold_en ? " idle" : ""));
    n_instr++;
  endtask

  initial begin
    logic hh;
    logic [15:0] t;
    do_reset();
    en = 1'b1;
    tick();
    run_instr(0, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, hh);
    run_instr(0, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, hh);
    run_instr(3, 16'hABCD, 1'b1, 16'h0040, 1'b1, 1'b0, hh);
    run_instr(0, 16'h5555, 1'b0, 16'h0000, 1'b1, 1'b0, hh);
    run_instr(TO - 1, 16'h0F0F, 1'b0, 16'h0000, 1'b0, 1'b0, hh);

    for (int k = 0; k < 40; k++) begin
      int w;
      w = ($urandom_range(0, 19) == 0) ? int'($urandom_range(TO, TO + 2)) : int'($urandom_range(0, TO - 1));
      t = 16'($urandom) & 16'hFFFE;
      run_instr(w, 16'($urandom), ($urandom_range(0, 2) == 0), t,
                ($urandom_range(0, 5) != 0), ($urandom_range(0, 14) == 0), hh);
      if (hh) begin
        do_reset();
        en = 1'b1;
        tick();
      end
    end

    run_instr(20, 16'h7777, 1'b0, 16'h0000, 1'b1, 1'b0, hh);
    do_reset();

    en = 1'b1;
    tick();
    run_instr(0, 16'h2222, 1'b0, 16'h0000, 1'b1, 1'b0, hh);
    mem_ready = 1'b1;
    inst_in   = 16'h3333;
    tick();
    mem_ready = 1'b0;
    check("mid_dec_state", 32'(state), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    en    = 1'b0;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_pc", 32'(pc), 32'(RV));
    check("mid_rst_retired", 32'(retired), 32'd0);
    check("mid_rst_inst", 32'(inst_out), 32'd0);
    check("mid_rst_enables", 32'(enables), 32'd0);
    $display("reset during DECODE -> state %0d pc %h retired %0d", state, pc, retired);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
